// File: rtl/mux_arb_nxw.sv
// ============================================================================
//  Module   : mux_arb_nxw
//  Purpose  : N-channel, W-bit registered mux with valid/ready handshake and
//             a direct-select or round-robin grant. The optional transfer
//             counter port xfer_count is built when MUX_ARB_STATS_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mux_arb_nxw #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    data_q,    data_d;
    logic [SEL_W-1:0]    chan_q,    chan_d;
    logic                valid_q,   valid_d;
    logic [SEL_W-1:0]    rr_ptr_q,  rr_ptr_d;

    logic                accept;
    logic                dir_any;
    logic                rr_any;
    logic [SEL_W-1:0]    rr_idx;
    logic                grant_any;
    logic [SEL_W-1:0]    grant_idx;
    logic [CHANNELS-1:0] grant_onehot;

    assign accept = !valid_q || out_ready;

    // Out-of-range select is rejected before the in_valid lookup can matter.
    assign dir_any = ({1'b0, select} < CH_LIMIT) && in_valid[select];

    // Round-robin search starts just after the last granted channel and wraps.
    always_comb begin
        int k;
        rr_any = 1'b0;
        rr_idx = '0;
        k      = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            k = int'(rr_ptr_q) + i;
            if (k >= CHANNELS) begin
                k = k - CHANNELS;
            end
            if (!rr_any && in_valid[k]) begin
                rr_any = 1'b1;
                rr_idx = k[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        grant_any    = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        if (mode) begin
            grant_any = rr_any;
            grant_idx = rr_idx;
        end else begin
            grant_any = dir_any;
            grant_idx = select;
        end
        if (grant_any) begin
            grant_onehot = CHANNELS'(1) << grant_idx;
        end
    end

    // Reset gating keeps in_ready low even while the output stage is empty.
    assign in_ready = (accept && !reset) ? grant_onehot : '0;

    always_comb begin
        data_d   = data_q;
        chan_d   = chan_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            valid_d = grant_any;
            if (grant_any) begin
                data_d = in_data[grant_idx*WIDTH +: WIDTH];
                chan_d = grant_idx;
                if (mode) begin
                    rr_ptr_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= PTR_INIT;
        end else begin
            data_q   <= data_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data    = data_q;
    assign out_channel = chan_q;
    assign out_valid   = valid_q;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && grant_any && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_nxw.sv
// Directed bench for mux_arb_nxw (WIDTH=8, CHANNELS=8) with a queue scoreboard.
`default_nettype none

module tb_mux_arb_nxw;

    localparam int W = 8;
    localparam int N = 8;
    localparam int S = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [S-1:0]   select;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_channel;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]    xfer_count;
    int             m_cnt;
`endif

    mux_arb_nxw #(.WIDTH(W), .CHANNELS(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .select      (select),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef MUX_ARB_STATS_EN
        ,
        .xfer_count  (xfer_count)
`endif
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];
    logic        m_valid;
    logic [7:0]  m_data;
    logic [7:0]  m_chan;
    int          m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ch_data(input int k);
        return in_data[k*W +: W];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_chan  = 8'h00;
        m_ptr   = N - 1;
        sb.delete();
`ifdef MUX_ARB_STATS_EN
        m_cnt = 0;
`endif
    endtask

    // One cycle: drive at negedge, check in_ready, then check registered outputs after the edge.
    task automatic step(input logic [N-1:0] iv, input logic md, input int sel, input logic ordy);
        logic acc, g_any;
        int g_idx;
        logic [15:0] e;
        @(negedge clock);
        in_valid  = iv;
        mode      = md;
        select    = S'(sel);
        out_ready = ordy;
        #1;
        acc   = !m_valid || ordy;
        g_any = 1'b0;
        g_idx = 0;
        if (!md) begin
            if (sel < N && iv[sel]) begin g_any = 1'b1; g_idx = sel; end
        end else begin
            for (int j = 1; j <= N; j++) begin
                if (!g_any && iv[(m_ptr + j) % N]) begin g_any = 1'b1; g_idx = (m_ptr + j) % N; end
            end
        end
        chk("in_ready", 32'(in_ready), (acc && g_any) ? (32'd1 << g_idx) : 32'd0);
        if (acc && g_any) begin
            sb.push_back({8'(g_idx), ch_data(g_idx)});
            if (md) m_ptr = g_idx;
        end
        @(posedge clock);
        #1;
        if (acc) m_valid = g_any;
        if (acc && g_any) begin
            e = sb.pop_front();
            m_chan = e[15:8];
            m_data = e[7:0];
`ifdef MUX_ARB_STATS_EN
            if (m_cnt < 16'hFFFF) m_cnt++;
`endif
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_channel", 32'(out_channel), 32'(m_chan));
`ifdef MUX_ARB_STATS_EN
        chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
    endtask

    initial begin
        int order[6];
        order = '{0, 2, 5, 7, 0, 2};
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'h10 + 8'(k);
        reset = 1'b1; in_valid = '1; mode = 1'b0; select = '0; out_ready = 1'b1;
        model_reset();

        // 1. reset held two cycles with every channel requesting
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clock); reset = 1'b0;

        // 2. direct select sweep
        for (int s = 0; s < N; s++) begin
            step(8'hFF, 1'b0, s, 1'b1);
            chk("dir_data", 32'(out_data), 32'h10 + 32'(s));
            chk("dir_chan", 32'(out_channel), 32'(s));
        end

        // 3. round-robin over sparse requesters
        for (int i = 0; i < 6; i++) begin
            step(8'b1010_0101, 1'b1, 0, 1'b1);
            chk("rr_order", 32'(out_channel), 32'(order[i]));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end

        // 4. stall holding channel 2, then resume at channel 5
        for (int i = 0; i < 3; i++) begin
            step(8'b1010_0101, 1'b1, 0, 1'b0);
            chk("stall_data", 32'(out_data), 32'h12);
        end
        step(8'b1010_0101, 1'b1, 0, 1'b1);
        chk("resume_chan", 32'(out_channel), 32'd5);

        // 5. direct select of an idle channel: held word drains, data retained
        step(8'hF7, 1'b0, 3, 1'b1);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data", 32'(out_data), 32'h15);
        step(8'hF7, 1'b0, 3, 1'b1);

        // mode/select changed during a stall take effect only at the next accept
        step(8'hFF, 1'b0, 6, 1'b1);
        step(8'hFF, 1'b1, 1, 1'b0);
        step(8'hFF, 1'b0, 4, 1'b1);
        chk("late_sel", 32'(out_channel), 32'd4);

        // reset mid-transfer discards the held word and restarts priority at channel 0
        @(negedge clock); reset = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        @(negedge clock); reset = 1'b0;
        model_reset();
        step(8'hFF, 1'b1, 0, 1'b1);
        chk("post_rst_chan", 32'(out_channel), 32'd0);

`ifdef MUX_ARB_STATS_EN
        // 6. counter saturation and clear
        @(negedge clock); in_valid = '1; mode = 1'b1; out_ready = 1'b1;
        repeat (70000) @(posedge clock);
        #1;
        chk("cnt_sat", 32'(xfer_count), 32'hFFFF);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("cnt_clr", 32'(xfer_count), 32'd0);
        @(negedge clock); reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
